// File: rtl/beep_detector.sv
// Beep (square-wave tone) detector: measures half-periods of beep_in,
// qualifies a tone after enough in-range periods, reports its length.
//
// Ports:
//   clkout         in   sampling clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   beep_in        in   asynchronous square-wave tone input
//   enable         in   detection enable (low forces IDLE)
//   tone_present   out  high while a qualified tone is active
//   tone_start     out  one-cycle pulse when a tone qualifies
//   tone_end       out  one-cycle pulse when an active tone ends
//   duration       out  length of last completed tone, full periods
//   duration_valid out  one-cycle pulse when duration updates
//   half_period    out  last measured edge-to-edge interval, clkout cycles
module beep_detector #(
   parameter int MIN_HALF   = 40,
   parameter int MAX_HALF   = 60,
   parameter int MIN_CYCLES = 8
) (
   input  logic        clkout,
   input  logic        rst_n,
   input  logic        beep_in,
   input  logic        enable,
   output logic        tone_present,
   output logic        tone_start,
   output logic        tone_end,
   output logic [19:0] duration,
   output logic        duration_valid,
   output logic [15:0] half_period
);

   localparam logic [15:0] MIN_H    = 16'(MIN_HALF);
   localparam logic [15:0] MAX_H    = 16'(MAX_HALF);
   localparam logic [15:0] GOOD_TGT = 16'(2 * MIN_CYCLES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUALIFY = 2'd1,
      ACTIVE  = 2'd2
   } state_t;

   state_t      state, state_n;
   logic        sync0, sync1, hist;
   logic        edge_det;
   logic [15:0] hcnt;
   logic [15:0] good, good_n, good_inc;
   logic [19:0] dur, dur_n;
   logic [19:0] end_dur;
   logic        h_ok, h_bad, timeout;
   logic        start_ev, end_ev;
   logic        start_pend, end_pend;

   // Both polarities of the synchronized input count as an edge.
   assign edge_det = sync1 ^ hist;

   // hcnt still holds the pre-update interval during the edge cycle.
   assign h_ok     = edge_det && (hcnt >= MIN_H) && (hcnt <= MAX_H);
   assign h_bad    = edge_det && !h_ok;
   assign timeout  = !edge_det && (hcnt > MAX_H);
   assign good_inc = good + 16'd1;

   always_ff @(posedge clkout or negedge rst_n) begin
      if (!rst_n) begin
         sync0       <= 1'b0;
         sync1       <= 1'b0;
         hist        <= 1'b0;
         hcnt        <= 16'd0;
         half_period <= 16'd0;
      end else begin
         sync0 <= beep_in;
         sync1 <= sync0;
         hist  <= sync1;
         if (edge_det) begin
            hcnt        <= 16'd1;
            half_period <= hcnt;
         end else if (hcnt != 16'hFFFF) begin
            hcnt <= hcnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clkout or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         good       <= 16'd0;
         dur        <= 20'd0;
         end_dur    <= 20'd0;
         start_pend <= 1'b0;
         end_pend   <= 1'b0;
      end else begin
         state      <= state_n;
         good       <= good_n;
         dur        <= dur_n;
         start_pend <= start_ev;
         end_pend   <= end_ev;
         // Round up: dur counts half-periods of the tone.
         if (end_ev)
            end_dur <= 20'((21'(dur) + 21'd1) >> 1);
      end
   end

   always_comb begin
      state_n  = state;
      good_n   = good;
      dur_n    = dur;
      start_ev = 1'b0;
      end_ev   = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         good_n  = 16'd0;
         dur_n   = 20'd0;
         end_ev  = (state == ACTIVE);
      end else begin
         unique case (state)
            IDLE: begin
               // First edge is only a timing reference.
               if (edge_det) begin
                  state_n = QUALIFY;
                  good_n  = 16'd0;
               end
            end
            QUALIFY: begin
               if (h_ok) begin
                  good_n = good_inc;
                  if (good_inc == GOOD_TGT) begin
                     state_n  = ACTIVE;
                     dur_n    = 20'(good_inc);
                     start_ev = 1'b1;
                  end
               end else if (h_bad) begin
                  good_n = 16'd0;
               end else if (timeout) begin
                  state_n = IDLE;
                  good_n  = 16'd0;
               end
            end
            ACTIVE: begin
               if (h_ok) begin
                  if (dur != 20'hFFFFF)
                     dur_n = dur + 20'd1;
               end else if (h_bad || timeout) begin
                  state_n = IDLE;
                  good_n  = 16'd0;
                  dur_n   = 20'd0;
                  end_ev  = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               good_n  = 16'd0;
               dur_n   = 20'd0;
            end
         endcase
      end
   end

   // Outputs trail the state register by one cycle.
   always_ff @(posedge clkout or negedge rst_n) begin
      if (!rst_n) begin
         tone_present   <= 1'b0;
         tone_start     <= 1'b0;
         tone_end       <= 1'b0;
         duration_valid <= 1'b0;
         duration       <= 20'd0;
      end else begin
         tone_present   <= (state == ACTIVE);
         tone_start     <= start_pend;
         tone_end       <= end_pend;
         duration_valid <= end_pend;
         if (end_pend)
            duration <= end_dur;
      end
   end

endmodule

// File: tb/tb_beep_detector.sv
// Self-checking bench for beep_detector: directed tone scenarios with
// an event scoreboard of expected start/end pulses.
module tb_beep_detector;

   logic        clkout;
   logic        rst_n;
   logic        beep_in;
   logic        enable;
   logic        tone_present;
   logic        tone_start;
   logic        tone_end;
   logic [19:0] duration;
   logic        duration_valid;
   logic [15:0] half_period;

   typedef struct {
      int kind;
      int cyc;
      int dur;
   } ev_t;

   ev_t exp_q[$];
   int  cyc;
   int  n_cmp;
   int  n_err;

   beep_detector dut (
      .clkout        (clkout),
      .rst_n         (rst_n),
      .beep_in       (beep_in),
      .enable        (enable),
      .tone_present  (tone_present),
      .tone_start    (tone_start),
      .tone_end      (tone_end),
      .duration      (duration),
      .duration_valid(duration_valid),
      .half_period   (half_period)
   );

   initial clkout = 1'b0;
   always #5 clkout = ~clkout;

   initial cyc = 0;
   always @(posedge clkout) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Transition i lands #1 after posedge cyc; a qualifying transition
   // shows up as tone_start four posedges later.
   task automatic wave(input int n, input int half, input int start_at,
                       output int last_k);
      last_k = 0;
      for (int i = 1; i <= n; i++) begin
         repeat (half) @(posedge clkout);
         #1 beep_in = ~beep_in;
         last_k = cyc;
         if (i == start_at)
            exp_q.push_back('{kind: 0, cyc: cyc + 4, dur: 0});
      end
   endtask

   // Timeout end: hcnt loads 1 three posedges after the transition,
   // reaches 61, then two more registered stages.
   task automatic push_end(input int k, input int d);
      exp_q.push_back('{kind: 1, cyc: k + 65, dur: d});
   endtask

   always @(negedge clkout) begin
      ev_t e;
      if (tone_start || duration_valid) begin
         e = '{kind: -1, cyc: -1, dur: -1};
         if (exp_q.size() > 0)
            e = exp_q.pop_front();
         check("ev_kind", duration_valid ? 1 : 0, e.kind);
         check("ev_cycle", cyc, e.cyc);
         if (duration_valid) begin
            check("end_duration", duration, e.dur);
            check("end_pulse", tone_end, 1);
            check("end_present", tone_present, 0);
         end else begin
            check("start_present", tone_present, 1);
         end
      end
   end

   initial begin
      int k;
      int m;
      n_cmp   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      enable  = 1'b1;
      beep_in = 1'b0;
      repeat (3) @(posedge clkout);
      #1;
      check("rst_present", tone_present, 0);
      check("rst_start", tone_start, 0);
      check("rst_end", tone_end, 0);
      check("rst_dv", duration_valid, 0);
      check("rst_duration", duration, 0);
      check("rst_half", half_period, 0);
      @(posedge clkout);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clkout);

      // 20 periods at 50, then hold: 39 half-periods -> 20 periods.
      wave(40, 50, 17, k);
      push_end(k, 20);
      repeat (100) @(posedge clkout);
      #1 check("r029_half", half_period, 50);

      // Too-short half-period never qualifies.
      wave(100, 30, 0, k);
      #1 check("r030_half", half_period, 30);
      repeat (100) @(posedge clkout);

      // 7 periods only: no start, timeout back to IDLE.
      wave(14, 50, 0, k);
      repeat (100) @(posedge clkout);
      #1;
      check("r031_idle", dut.state, 0);
      check("r031_duration", duration, 20);
      check("r031_present", tone_present, 0);

      // Stretched half-period ends tone; late edge restarts qualifying.
      wave(20, 50, 17, k);
      push_end(k, 10);
      wave(1, 70, 0, k);
      check("r032_present", tone_present, 0);
      wave(20, 50, 16, k);
      push_end(k, 10);
      repeat (100) @(posedge clkout);
      #1 check("r032_half", half_period, 50);

      // enable dropped after 12 periods.
      wave(24, 50, 17, k);
      repeat (10) @(posedge clkout);
      #1 enable = 1'b0;
      m = cyc;
      exp_q.push_back('{kind: 1, cyc: m + 2, dur: 12});
      repeat (5) @(posedge clkout);
      #1 check("r034_present", tone_present, 0);
      enable = 1'b1;
      repeat (100) @(posedge clkout);

      // Reset mid-tone: async clear, no end pulse afterwards.
      wave(20, 50, 17, k);
      repeat (10) @(posedge clkout);
      #1 check("r033_pre_present", tone_present, 1);
      rst_n = 1'b0;
      #2;
      check("r033_present", tone_present, 0);
      check("r033_start", tone_start, 0);
      check("r033_end", tone_end, 0);
      check("r033_dv", duration_valid, 0);
      check("r033_duration", duration, 0);
      check("r033_half", half_period, 0);
      repeat (3) @(posedge clkout);
      #1 rst_n = 1'b1;
      repeat (150) @(posedge clkout);
      #1;
      check("r033_after_present", tone_present, 0);
      check("pending_events", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/beep_detector.md
BEEP_DETECTOR -- requirements
Module: beep_detector

Interface
REQ-001 The block SHALL have parameter MIN_HALF, default 40, meaning shortest accepted half-period in clkout cycles.
REQ-002 The block SHALL have parameter MAX_HALF, default 60, meaning longest accepted half-period in clkout cycles; legal range MIN_HALF..65534.
REQ-003 The block SHALL have parameter MIN_CYCLES, default 8, meaning full periods required before a tone is declared; legal range 1..32767.
REQ-004 The block SHALL have port clkout, input, 1 bit, the sampling clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port beep_in, input, 1 bit, the square-wave tone input, asynchronous to clkout.
REQ-007 The block SHALL have port enable, input, 1 bit, detection enable, synchronous to clkout.
REQ-008 The block SHALL have port tone_present, output, 1 bit, high while a qualified tone is active.
REQ-009 The block SHALL have port tone_start, output, 1 bit, one-cycle pulse when a tone qualifies.
REQ-010 The block SHALL have port tone_end, output, 1 bit, one-cycle pulse when an active tone ends.
REQ-011 The block SHALL have port duration, output, 20 bits, length of the last completed tone in full periods.
REQ-012 The block SHALL have port duration_valid, output, 1 bit, one-cycle pulse when duration updates.
REQ-013 The block SHALL have port half_period, output, 16 bits, last measured edge-to-edge interval in clkout cycles.

Function
REQ-014 beep_in SHALL pass a 2-flop synchronizer plus one history flop; edge = XOR of last two stages, i.e. both polarities.
REQ-015 Half-period counter hcnt (16 bit) SHALL load 1 on an edge cycle, otherwise increment, saturating at 65535.
REQ-016 On an edge, the pre-update hcnt value SHALL be the measured interval h; half_period <= h the next cycle.
REQ-017 h SHALL be valid iff MIN_HALF <= h <= MAX_HALF; timeout SHALL be hcnt > MAX_HALF in a non-edge cycle.
REQ-018 FSM states SHALL be IDLE, QUALIFY, ACTIVE; reset state IDLE.
REQ-019 IDLE: on edge go QUALIFY, good <= 0; the first edge is a reference only, no measurement.
REQ-020 QUALIFY: valid edge -> good+1; invalid edge -> good <= 0, stay QUALIFY; timeout -> IDLE.
REQ-021 QUALIFY: when a valid edge makes good = 2*MIN_CYCLES, go ACTIVE, dur <= good, tone_start pulse and tone_present=1 registered the following cycle.
REQ-022 ACTIVE: valid edge -> dur+1, saturating at 2^20-1.
REQ-023 ACTIVE: invalid edge or timeout -> IDLE; next cycle tone_present=0, tone_end=1, duration_valid=1, duration = (dur+1)>>1.
REQ-024 enable low SHALL force IDLE and clear good and dur; if leaving ACTIVE, emit the REQ-023 outputs; hcnt keeps counting.
REQ-025 Invalid edge and timeout cannot coincide; an edge cycle SHALL never count as timeout.
REQ-026 Outputs SHALL be registered; beep_in transition to tone_start latency = 4 clkout cycles.

Reset
REQ-027 Reset SHALL set state IDLE, good, dur and hcnt 0, all synchronizer flops 0, tone_present/tone_start/tone_end/duration_valid 0, duration 0, half_period 0.
REQ-028 Reset during ACTIVE SHALL NOT produce tone_end or duration_valid, during or after reset.

Verification
REQ-029 Defaults; 20 full periods, half-period 50, then hold low -> tone_start 4 cycles after the 17th transition; tone_end and duration_valid 62 cycles after the last synchronized edge; duration=20; half_period=50.
REQ-030 Half-period 30 for 50 periods -> tone_start never asserts; half_period=30.
REQ-031 7 full periods at half-period 50 -> no tone_start; FSM back to IDLE after timeout; duration unchanged.
REQ-032 Active tone, one half-period stretched to 70 -> tone_end when hcnt reaches 61; new qualification restarts at the late edge.
REQ-033 rst_n low mid-tone -> all outputs 0 asynchronously; no tone_end pulse after release.
REQ-034 enable dropped mid-tone after 12 periods -> tone_end and duration_valid next cycle with duration=12.
